// File: rtl/lms_dist_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lms_dist_fifo
// Description : Single-clock FIFO on distributed (LUT) RAM for the LMS filter
//               path. Provides full/empty, programmable almost-full and
//               almost-empty flags, a fill-level count, overflow/underflow
//               pulses and a 1- or 2-cycle read latency (OUT_REG).
// Ports       : wr_clk          sole clock
//               asyn_rst        asynchronous active-high reset
//               wr_en_i         write request
//               wr_data_i       write word
//               rd_en_i         read request
//               rd_data_o       read word (holds when rd_valid_o is low)
//               rd_valid_o      rd_data_o carries a newly read word
//               full_o          level == DEPTH
//               almost_full_o   level >= ALMOST_FULL_NUM
//               empty_o         level == 0
//               almost_empty_o  level <= ALMOST_EMPTY_NUM
//               level_o         stored word count, 0..DEPTH
//               overflow_o      one-cycle pulse, write rejected
//               underflow_o     one-cycle pulse, read rejected
// Revision    : 1.0 - initial release
// ============================================================================
module lms_dist_fifo #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int OUT_REG          = 0,
    parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int                c_DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_LVL = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF_LVL    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] c_AE_LVL    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    // Storage: synchronous write, asynchronous read, never reset.
    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q,  rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,   level_d;
    logic                  full_q,    full_d;
    logic                  afull_q,   afull_d;
    logic                  empty_q,   empty_d;
    logic                  aempty_q,  aempty_d;
    logic                  ovf_q,     ovf_d;
    logic                  udf_q,     udf_d;
    logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
    logic                  rd_valid1_q;

    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the registered flags, so a full FIFO never takes a
    // write even if a read drains it in the same cycle (and vice versa).
    assign wr_acc = wr_en_i & ~full_q;
    assign rd_acc = rd_en_i & ~empty_q;

    always_ff @(posedge wr_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data1_d = rd_data1_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data1_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end

        if (wr_acc && !rd_acc) begin
            level_d = level_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - 1'b1;
        end

        // Flags track the next level so they move on the same edge as it.
        full_d   = (level_d == c_DEPTH_LVL);
        afull_d  = (level_d >= c_AF_LVL);
        empty_d  = (level_d == '0);
        aempty_d = (level_d <= c_AE_LVL);
        ovf_d    = wr_en_i & full_q;
        udf_d    = rd_en_i & empty_q;
    end

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            rd_data1_q  <= '0;
            rd_valid1_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rd_data1_q  <= rd_data1_d;
            rd_valid1_q <= rd_acc;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Free-running second stage: stage 1 holds its word when idle,
            // so copying every cycle keeps rd_data_o stable between reads.
            logic [DATA_WIDTH-1:0] rd_data2_q;
            logic                  rd_valid2_q;

            always_ff @(posedge wr_clk or posedge asyn_rst) begin
                if (asyn_rst) begin
                    rd_data2_q  <= '0;
                    rd_valid2_q <= 1'b0;
                end else begin
                    rd_data2_q  <= rd_data1_q;
                    rd_valid2_q <= rd_valid1_q;
                end
            end

            assign rd_data_o  = rd_data2_q;
            assign rd_valid_o = rd_valid2_q;
        end else begin : g_no_out_reg
            assign rd_data_o  = rd_data1_q;
            assign rd_valid_o = rd_valid1_q;
        end
    endgenerate

    assign full_o         = full_q;
    assign almost_full_o  = afull_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = aempty_q;
    assign level_o        = level_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_dist_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_lms_dist_fifo
// Description : Bench for lms_dist_fifo. Two instances (OUT_REG=0 and 1)
//               share one stimulus stream; a queue-based model predicts
//               level, flags, pulses and read data for both every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lms_dist_fifo;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AFN   = DEPTH - 2;
    localparam int AEN   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          we, re;
    logic [DW-1:0] wd;

    logic [DW-1:0] rd0, rd1;
    logic          v0, v1, f0, f1, af0, af1, e0, e1, ae0, ae1;
    logic          of0, of1, uf0, uf1;
    logic [AW:0]   l0, l1;

    always #5 clk = ~clk;

    lms_dist_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0),
                    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_dut0 (
        .wr_clk(clk), .asyn_rst(rst), .wr_en_i(we), .wr_data_i(wd), .rd_en_i(re),
        .rd_data_o(rd0), .rd_valid_o(v0), .full_o(f0), .almost_full_o(af0),
        .empty_o(e0), .almost_empty_o(ae0), .level_o(l0),
        .overflow_o(of0), .underflow_o(uf0));

    lms_dist_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1),
                    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_dut1 (
        .wr_clk(clk), .asyn_rst(rst), .wr_en_i(we), .wr_data_i(wd), .rd_en_i(re),
        .rd_data_o(rd1), .rd_valid_o(v1), .full_o(f1), .almost_full_o(af1),
        .empty_o(e1), .almost_empty_o(ae1), .level_o(l1),
        .overflow_o(of1), .underflow_o(uf1));

    // Behavioural model: contents as a queue, plus the expected read outputs.
    logic [DW-1:0] q[$];
    logic          m_v0, m_v1, m_of, m_uf;
    logic [DW-1:0] m_d0, m_d1;

    int n_cmp = 0;
    int n_bad = 0;
    int pushed;
    int iter;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_v0 = 1'b0; m_v1 = 1'b0; m_of = 1'b0; m_uf = 1'b0;
        m_d0 = '0;   m_d1 = '0;
    endtask

    // One clock edge of the reference: decide acceptance from the level
    // before the edge, then update contents and the read pipeline.
    task automatic model_edge();
        bit is_full, is_empty, wacc, racc;
        is_full  = (q.size() == DEPTH);
        is_empty = (q.size() == 0);
        wacc     = we && !is_full;
        racc     = re && !is_empty;
        m_v1     = m_v0;
        m_d1     = m_d0;
        m_v0     = racc;
        if (racc) m_d0 = q.pop_front();
        if (wacc) q.push_back(wd);
        m_of = we && is_full;
        m_uf = re && is_empty;
    endtask

    task automatic check_all();
        int lvl;
        lvl = q.size();
        chk("level0", 32'(l0), 32'(lvl));
        chk("level1", 32'(l1), 32'(lvl));
        chk("full0", 32'(f0), 32'(lvl == DEPTH));
        chk("full1", 32'(f1), 32'(lvl == DEPTH));
        chk("afull0", 32'(af0), 32'(lvl >= AFN));
        chk("afull1", 32'(af1), 32'(lvl >= AFN));
        chk("empty0", 32'(e0), 32'(lvl == 0));
        chk("empty1", 32'(e1), 32'(lvl == 0));
        chk("aempty0", 32'(ae0), 32'(lvl <= AEN));
        chk("aempty1", 32'(ae1), 32'(lvl <= AEN));
        chk("ovf0", 32'(of0), 32'(m_of));
        chk("ovf1", 32'(of1), 32'(m_of));
        chk("udf0", 32'(uf0), 32'(m_uf));
        chk("udf1", 32'(uf1), 32'(m_uf));
        chk("rvalid0", 32'(v0), 32'(m_v0));
        chk("rdata0", 32'(rd0), 32'(m_d0));
        chk("rvalid1", 32'(v1), 32'(m_v1));
        chk("rdata1", 32'(rd1), 32'(m_d1));
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        we = w; wd = d; re = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; wd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("lit_rst_empty", 32'(e0), 32'd1);
        chk("lit_rst_level", 32'(l0), 32'd0);
        chk("lit_rst_aempty", 32'(ae1), 32'd1);
        rst = 1'b0;

        // Fill with 1..16, then one rejected write.
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i == 13) chk("lit_afull_before", 32'(af0), 32'd0);
            if (i == 14) chk("lit_afull_rise", 32'(af0), 32'd1);
            if (i == 16) chk("lit_full_level", 32'(l0), 32'd16);
            if (i == 17) chk("lit_overflow", 32'(of0), 32'd1);
        end
        step(1'b0, '0, 1'b0);

        // Drain, then one rejected read.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1);
            if (i == 1)  chk("lit_first_word", 32'(rd0), 32'h0001);
            if (i == 13) chk("lit_aempty_before", 32'(ae0), 32'd0);
            if (i == 14) chk("lit_aempty_rise", 32'(ae0), 32'd1);
            if (i == 16) chk("lit_last_word", 32'(rd0), 32'h0010);
        end
        step(1'b0, '0, 1'b1);
        chk("lit_underflow", 32'(uf0), 32'd1);
        chk("lit_udf_novalid", 32'(v0), 32'd0);
        step(1'b0, '0, 1'b0);

        // Empty with both requests: write wins.
        step(1'b1, 16'h0055, 1'b1);
        chk("lit_empty_both_level", 32'(l0), 32'd1);
        chk("lit_empty_both_udf", 32'(uf0), 32'd1);

        // Level 5, then 10 cycles of simultaneous read/write.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h0200 + i), 1'b1);
        chk("lit_both_level", 32'(l0), 32'd5);
        while (q.size() > 0) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Streaming wrap-around: 40 words with a shallow fill.
        pushed = 0;
        iter   = 0;
        while ((pushed < 40 || q.size() > 0) && iter < 300) begin
            bit w, r;
            w = (pushed < 40) && (q.size() == 0 || (q.size() < 3 && $urandom_range(0, 1) == 1));
            r = (q.size() >= 2) || (pushed == 40 && q.size() > 0);
            step(w, DW'($urandom), r);
            if (w) pushed++;
            iter++;
        end
        chk("wrap_done", 32'(pushed == 40 && q.size() == 0), 32'd1);
        step(1'b0, '0, 1'b0);

        // Read-latency burst: 4 consecutive reads.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h0A00 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("lit_lat1_valid_n1", 32'(v1), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("lit_lat1_valid_n2", 32'(v1), 32'd1);
        chk("lit_lat1_data", 32'(rd1), 32'h0A00);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

        // Full with both requests: read wins.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b1, 16'hDEAD, 1'b1);
        chk("lit_full_both_level", 32'(l0), 32'd15);
        chk("lit_full_both_ovf", 32'(of0), 32'd1);
        while (q.size() > 0) step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 100) % 2;
            step($urandom_range(0, 3) > bias, DW'($urandom), $urandom_range(0, 3) > (1 - bias));
        end

        // Reset mid-burst: level 9 with a read in flight.
        while (q.size() > 0) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h0C00 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        #2;
        rst = 1'b1;
        re  = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("lit_mid_rst_empty", 32'(e0), 32'd1);
        chk("lit_mid_rst_level", 32'(l1), 32'd0);
        chk("lit_mid_rst_valid0", 32'(v0), 32'd0);
        chk("lit_mid_rst_valid1", 32'(v1), 32'd0);
        #2;
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b1, 16'hABCD, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("lit_post_rst_data0", 32'(rd0), 32'h0000ABCD);
        step(1'b0, '0, 1'b0);
        chk("lit_post_rst_data1", 32'(rd1), 32'h0000ABCD);
        step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
